// File: rtl/count_seq_checker.sv
// Downstream sequence checker for a free-running up-counter: verifies +1 steps,
// reports legal wraps, flags mismatches and latches a sticky fault.
module count_seq_checker #(
    parameter int WIDTH      = 4,
    parameter int ERR_LIMIT  = 3,
    parameter int WRAP_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [WIDTH-1:0]      cnt_in,
    input  logic                  clr_err,
    output logic                  wrap_pulse,
    output logic [WRAP_CNT_W-1:0] wrap_count,
    output logic                  mismatch,
    output logic                  fault,
    output logic [1:0]            state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        TRACK = 2'd2,
        FAULT = 2'd3
    } state_e;

    // ERR_LIMIT is at most 15, so a 4-bit tally always reaches it.
    localparam int                     TALLY_W  = 4;
    localparam logic [TALLY_W-1:0]     LIMIT    = TALLY_W'(ERR_LIMIT);
    localparam logic [WRAP_CNT_W-1:0]  WRAP_MAX = '1;

    state_e                  state_q, state_d;
    logic [WIDTH-1:0]        prev_q, prev_d;
    logic [TALLY_W-1:0]      tally_q, tally_d;
    logic [WRAP_CNT_W-1:0]   wrap_count_q, wrap_count_d;
    logic                    wrap_pulse_q, wrap_pulse_d;
    logic                    mismatch_q, mismatch_d;
    logic                    fault_q, fault_d;
    logic [WIDTH-1:0]        expected;

    // Sum is truncated to WIDTH, so all-ones predicts zero.
    assign expected = prev_q + WIDTH'(1);

    always_comb begin
        // NOTE: every _d signal gets a default first, so no path can infer a latch.
        state_d      = state_q;
        prev_d       = prev_q;
        tally_d      = tally_q;
        wrap_count_d = wrap_count_q;
        fault_d      = fault_q;
        wrap_pulse_d = 1'b0;
        mismatch_d   = 1'b0;

        if (clr_err) begin
            tally_d      = '0;
            wrap_count_d = '0;
            fault_d      = 1'b0;
            state_d      = en ? SYNC : IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (en) begin
                        state_d = SYNC;
                    end
                end
                SYNC: begin
                    if (!en) begin
                        state_d = IDLE;
                    end else begin
                        prev_d  = cnt_in;
                        state_d = TRACK;
                    end
                end
                TRACK: begin
                    if (!en) begin
                        state_d = IDLE;
                        tally_d = '0;
                    end else begin
                        // Resync on every sample so one glitch costs one flag, not a stream.
                        prev_d = cnt_in;
                        if (cnt_in == expected) begin
                            tally_d = '0;
                            if (cnt_in == '0) begin
                                wrap_pulse_d = 1'b1;
                                if (wrap_count_q != WRAP_MAX) begin
                                    wrap_count_d = wrap_count_q + WRAP_CNT_W'(1);
                                end
                            end
                        end else begin
                            mismatch_d = 1'b1;
                            tally_d    = tally_q + TALLY_W'(1);
                            if (tally_d == LIMIT) begin
                                state_d = FAULT;
                                fault_d = 1'b1;
                            end
                        end
                    end
                end
                FAULT: begin
                    fault_d = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            prev_q       <= '0;
            tally_q      <= '0;
            wrap_count_q <= '0;
            wrap_pulse_q <= 1'b0;
            mismatch_q   <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register updates from pre-edge values.
            state_q      <= state_d;
            prev_q       <= prev_d;
            tally_q      <= tally_d;
            wrap_count_q <= wrap_count_d;
            wrap_pulse_q <= wrap_pulse_d;
            mismatch_q   <= mismatch_d;
            fault_q      <= fault_d;
        end
    end

    assign wrap_pulse = wrap_pulse_q;
    assign wrap_count = wrap_count_q;
    assign mismatch   = mismatch_q;
    assign fault      = fault_q;
    assign state      = state_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// Scoreboard bench for count_seq_checker: stimulus queues hand-computed responses,
// a monitor compares them one cycle after each sampling edge.
module tb_count_seq_checker;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SYNC  = 2'd1;
    localparam logic [1:0] ST_TRACK = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    logic       clk;
    logic       reset;
    logic       en;
    logic [3:0] cnt_in;
    logic       clr_err;

    logic       wrap_pulse, mismatch, fault;
    logic [7:0] wrap_count;
    logic [1:0] state;
    logic       wrap_pulse2, mismatch2, fault2;
    logic [1:0] wrap_count2;
    logic [1:0] state2;

    typedef struct {
        logic [1:0] st;
        logic       wp;
        logic [7:0] wc;
        logic [1:0] wc2;
        logic       mm;
        logic       flt;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    count_seq_checker dut (
        .clk(clk), .reset(reset), .en(en), .cnt_in(cnt_in), .clr_err(clr_err),
        .wrap_pulse(wrap_pulse), .wrap_count(wrap_count), .mismatch(mismatch),
        .fault(fault), .state(state)
    );

    count_seq_checker #(.WRAP_CNT_W(2)) dut_w2 (
        .clk(clk), .reset(reset), .en(en), .cnt_in(cnt_in), .clr_err(clr_err),
        .wrap_pulse(wrap_pulse2), .wrap_count(wrap_count2), .mismatch(mismatch2),
        .fault(fault2), .state(state2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one sample at the negedge and queue the response due after the next posedge.
    task automatic step(input logic e, input logic [3:0] c, input logic clr,
                        input logic [1:0] st, input logic wp, input int wc,
                        input logic mm, input logic flt);
        exp_t x;
        @(negedge clk);
        en      = e;
        cnt_in  = c;
        clr_err = clr;
        x.st  = st;
        x.wp  = wp;
        x.wc  = 8'(wc);
        x.wc2 = (wc > 3) ? 2'd3 : 2'(wc);
        x.mm  = mm;
        x.flt = flt;
        q.push_back(x);
    endtask

    // Monitor: outputs are registered, so compare 1 ns after each rising edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                check("state",       32'(state),       32'(x.st));
                check("wrap_pulse",  32'(wrap_pulse),  32'(x.wp));
                check("wrap_count",  32'(wrap_count),  32'(x.wc));
                check("mismatch",    32'(mismatch),    32'(x.mm));
                check("fault",       32'(fault),       32'(x.flt));
                check("w2_pulse",    32'(wrap_pulse2), 32'(x.wp));
                check("w2_count",    32'(wrap_count2), 32'(x.wc2));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int wc;
        logic [3:0] c;
        logic wp;

        reset = 1'b0; en = 1'b0; cnt_in = '0; clr_err = 1'b0;
        #2;
        check("por_state",  32'(state),      32'd0);
        check("por_count",  32'(wrap_count), 32'd0);
        check("por_pulse",  32'(wrap_pulse), 32'd0);
        check("por_mm",     32'(mismatch),   32'd0);
        check("por_fault",  32'(fault),      32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Clean run from 0: SYNC at 0, TRACK from 1, five wraps (W2 copy saturates at 3).
        wc = 0;
        step(1, 4'd0, 0, ST_SYNC,  0, 0, 0, 0);
        step(1, 4'd1, 0, ST_TRACK, 0, 0, 0, 0);
        for (int k = 2; k <= 81; k++) begin
            c  = 4'(k % 16);
            wp = (c == 4'd0);
            if (wp) wc++;
            step(1, c, 0, ST_TRACK, wp, wc, 0, 0);
        end

        // Single mismatch, recovery, a non-wrapping zero, then three in a row -> FAULT.
        for (int v = 2; v <= 5; v++) step(1, 4'(v), 0, ST_TRACK, 0, 5, 0, 0);
        step(1, 4'd9,  0, ST_TRACK, 0, 5, 1, 0);
        step(1, 4'd10, 0, ST_TRACK, 0, 5, 0, 0);
        step(1, 4'd11, 0, ST_TRACK, 0, 5, 0, 0);
        step(1, 4'd0,  0, ST_TRACK, 0, 5, 1, 0);
        step(1, 4'd1,  0, ST_TRACK, 0, 5, 0, 0);
        step(1, 4'd2,  0, ST_TRACK, 0, 5, 0, 0);
        step(1, 4'd3,  0, ST_TRACK, 0, 5, 0, 0);
        step(1, 4'd7,  0, ST_TRACK, 0, 5, 1, 0);
        step(1, 4'd2,  0, ST_TRACK, 0, 5, 1, 0);
        step(1, 4'd12, 0, ST_FAULT, 0, 5, 1, 1);
        step(1, 4'd13, 0, ST_FAULT, 0, 5, 0, 1);
        step(0, 4'd5,  0, ST_FAULT, 0, 5, 0, 1);

        // Clear with en high: SYNC, then TRACK; fault and wrap_count cleared.
        step(1, 4'd6, 1, ST_SYNC,  0, 0, 0, 0);
        step(1, 4'd7, 0, ST_TRACK, 0, 0, 0, 0);
        wc = 0;
        for (int v = 8; v <= 23; v++) begin
            c  = 4'(v % 16);
            wp = (c == 4'd0);
            if (wp) wc++;
            step(1, c, 0, ST_TRACK, wp, wc, 0, 0);
        end

        // Enable gap from 8 to 12, re-raise at 13: no mismatch, wrap_count held.
        step(0, 4'd8, 0, ST_IDLE, 0, 1, 0, 0);
        for (int v = 9; v <= 12; v++) step(0, 4'(v), 0, ST_IDLE, 0, 1, 0, 0);
        step(1, 4'd13, 0, ST_SYNC,  0, 1, 0, 0);
        step(1, 4'd14, 0, ST_TRACK, 0, 1, 0, 0);
        step(1, 4'd15, 0, ST_TRACK, 0, 1, 0, 0);
        step(1, 4'd0,  0, ST_TRACK, 1, 2, 0, 0);
        step(1, 4'd1,  0, ST_TRACK, 0, 2, 0, 0);
        step(1, 4'd2,  0, ST_TRACK, 0, 2, 0, 0);
        step(1, 4'd7,  0, ST_TRACK, 0, 2, 1, 0);

        // Asynchronous reset between edges while wrap_count=2 and mismatch=1.
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("arst_state",  32'(state),       32'd0);
        check("arst_count",  32'(wrap_count),  32'd0);
        check("arst_mm",     32'(mismatch),    32'd0);
        check("arst_pulse",  32'(wrap_pulse),  32'd0);
        check("arst_fault",  32'(fault),       32'd0);
        check("arst_w2cnt",  32'(wrap_count2), 32'd0);
        @(negedge clk);
        en = 1'b0; cnt_in = '0; reset = 1'b1;
        step(1, 4'd5, 0, ST_SYNC,  0, 0, 0, 0);
        step(1, 4'd6, 0, ST_TRACK, 0, 0, 0, 0);
        step(1, 4'd7, 0, ST_TRACK, 0, 0, 0, 0);

        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        #2;
        check("queue_drain", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/count_seq_checker.md
Name: count_seq_checker

Overview:
Downstream monitor for the 4-bit free-running up-counter. Samples the counter output every clock and checks that it advances by exactly +1 (mod 2^WIDTH). Emits a registered wrap pulse, counts wraps, flags mismatches, and latches a sticky fault after ERR_LIMIT consecutive mismatches. Used in simulation benches and as an on-chip sanity checker.

Parameters:
WIDTH, 4, width of the monitored count value.
ERR_LIMIT, 3, consecutive mismatches that force FAULT; legal range 1..15.
WRAP_CNT_W, 8, width of the saturating wrap counter.

Ports:
clk  input  1  rising-edge clock, same clock as the counter.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
en  input  1  checking enable.
cnt_in  input  WIDTH  counter value under check.
clr_err  input  1  synchronous clear of fault, error tally and wrap_count.
wrap_pulse  output  1  one-cycle pulse on each legal wrap (all-ones to 0).
wrap_count  output  WRAP_CNT_W  saturating count of legal wraps.
mismatch  output  1  one-cycle flag: the last sample broke the +1 sequence.
fault  output  1  sticky fault flag.
state  output  2  FSM state: IDLE=0, SYNC=1, TRACK=2, FAULT=3.

Behaviour:
- Reset asserted (reset=0): asynchronous, no clock edge needed. state=IDLE, wrap_pulse=0, wrap_count=0, mismatch=0, fault=0, internal expected value=0, consecutive-error tally=0.
- Every output is registered. A response appears one cycle after the clk edge that sampled cnt_in.
- Per-edge priority: reset > clr_err > en > sequence check.
- IDLE: outputs idle; no checking. en=1 -> SYNC.
- SYNC: capture cnt_in as prev and go to TRACK. Never flags mismatch. en=0 -> IDLE.
- TRACK, each edge: expected = prev + 1, truncated to WIDTH (15+1 = 0).
  - Match: mismatch=0 next cycle; tally cleared. If cnt_in==0, wrap_pulse=1 for one cycle and wrap_count increments (holds at 2^WRAP_CNT_W - 1).
  - Mismatch: mismatch=1 for one cycle; tally increments; prev resyncs to cnt_in, so the next check expects cnt_in + 1.
  - A mismatching sample of 0 is not a wrap and produces no wrap_pulse.
  - When tally reaches ERR_LIMIT: state -> FAULT and fault=1 on the same edge that registers that mismatch.
  - en=0 -> IDLE. Tally clears; wrap_count holds.
- FAULT: fault stays 1. en has no effect and checking stops.
  - clr_err=1 -> SYNC if en=1, else IDLE. fault=0, tally=0, wrap_count=0.
- clr_err in IDLE, SYNC or TRACK: clears tally and wrap_count. In TRACK it also re-enters SYNC, so that edge does no check, no mismatch and no wrap.
- cnt_in is sampled only at rising clk edges. Glitches between edges are ignored.
- Reset mid-operation: immediate return to reset values. After release, the first edge with en=1 enters SYNC.

Test Plan:
1. Counter running 0..15, en=1 from count 0: SYNC at 0, TRACK thereafter. At the edge sampling 15->0, wrap_pulse=1 for exactly one cycle, wrap_count=1, mismatch stays 0. After 3 full wraps, wrap_count=3.
2. In TRACK, force cnt_in=9 where 6 is expected, then resume 10,11: mismatch=1 for one cycle only, then 0. Tally returns to 0 and fault=0.
3. ERR_LIMIT=3, drive 3,7,2,12 in TRACK (three consecutive mismatches after 3): fault=1 and state=3 one cycle after sampling 12. Pulse clr_err with en=1: state=1, then 2; fault=0, wrap_count=0.
4. WRAP_CNT_W=2, run 5 legal wraps: wrap_count reads 1,2,3,3,3. wrap_pulse still fires on every wrap.
5. Assert reset low mid-TRACK, between clock edges, with wrap_count=2 and mismatch=1: all outputs go to 0 and state=0 before the next clk edge. Release; the first en=1 edge gives state=1.
6. Drop en at count 8 and re-raise at count 13: state goes 0, then 1 at 13, then 2. No mismatch flagged across the gap; wrap_count unchanged.
